// File: rtl/nn_ram_arbiter.sv
// Round-robin arbiter sharing the single-port SoC RAM between fetch (M0), load/store (M1)
// and the VGA line reader (M2), with a bounded lock for bursts and one-cycle read return.
`timescale 1ns/1ps

module nn_ram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [2:0]        REQ,
    input  logic [2:0]        WE,
    input  logic [2:0]        LOCK,
    input  logic [3*AW-1:0]   ADDR,
    input  logic [3*DW-1:0]   WDATA,
    output logic [2:0]        GNT,
    output logic [2:0]        RVALID,
    output logic [DW-1:0]     RDATA,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [AW-1:0]     RAM_ADDR,
    output logic [DW-1:0]     RAM_WDATA,
    input  logic [DW-1:0]     RAM_RDATA
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK);
    // With a limit of one the first grant already exhausts the lock, so LOCKED is never entered.
    localparam bit         LOCK_OK  = (MAX_LOCK > 1);

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] owner, owner_nxt;
    logic [7:0] lcnt, lcnt_nxt;
    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic [1:0] cand1, cand2;
    logic [2:0] vld_p1;

    function automatic logic [1:0] next_idx(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign cand1 = next_idx(last);
    assign cand2 = next_idx(cand1);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        owner_nxt = owner;
        lcnt_nxt  = lcnt;
        gnt_idx   = 2'd0;
        gnt_any   = 1'b0;
        case (state)
            ARB: begin
                if (REQ[cand1]) begin
                    gnt_idx = cand1;
                    gnt_any = 1'b1;
                end else if (REQ[cand2]) begin
                    gnt_idx = cand2;
                    gnt_any = 1'b1;
                end else if (REQ[last]) begin
                    gnt_idx = last;
                    gnt_any = 1'b1;
                end
                if (gnt_any) begin
                    last_nxt = gnt_idx;
                    if (LOCK[gnt_idx] && LOCK_OK) begin
                        state_nxt = LOCKED;
                        owner_nxt = gnt_idx;
                        lcnt_nxt  = 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (REQ[owner]) begin
                    gnt_idx  = owner;
                    gnt_any  = 1'b1;
                    last_nxt = owner;
                    lcnt_nxt = lcnt + 8'd1;
                    if (!LOCK[owner] || (lcnt_nxt >= LOCK_LIM)) begin
                        state_nxt = ARB;
                        lcnt_nxt  = 8'd0;
                    end
                end else begin
                    // Owner walked away: release without a grant, others compete next cycle.
                    state_nxt = ARB;
                    lcnt_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = ARB;
                lcnt_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ARB;
            last  <= 2'd2;
            owner <= 2'd0;
            lcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            owner <= owner_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // Stage p0: grant and RAM drive, combinational from the winning requester.
    assign GNT       = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    assign RAM_EN    = gnt_any;
    assign RAM_WE    = gnt_any & WE[gnt_idx];
    assign RAM_ADDR  = gnt_any ? ADDR[gnt_idx*AW +: AW] : '0;
    assign RAM_WDATA = gnt_any ? WDATA[gnt_idx*DW +: DW] : '0;

    // Stage p1: read return, tagged with the requester granted one cycle earlier.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1 <= 3'b000;
        end else begin
            vld_p1 <= GNT & ~WE;
        end
    end

    assign RVALID = vld_p1;
    assign RDATA  = RAM_RDATA;

endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Scenario bench for nn_ram_arbiter with a behavioural single-port RAM and a read-return scoreboard.
`timescale 1ns/1ps

module tb_nn_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int ML = 4;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [2:0]      REQ, WE, LOCK;
    logic [3*AW-1:0] ADDR;
    logic [3*DW-1:0] WDATA;
    logic [2:0]      GNT, RVALID;
    logic [DW-1:0]   RDATA;
    logic            RAM_EN, RAM_WE;
    logic [AW-1:0]   RAM_ADDR;
    logic [DW-1:0]   RAM_WDATA, RAM_RDATA;

    nn_ram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .LOCK(LOCK),
        .ADDR(ADDR), .WDATA(WDATA), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM: registered read, writes visible to the next cycle's read.
    logic [DW-1:0] ram [0:1023];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    always @(posedge CLK) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (RAM_EN) begin
            if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
            else        RAM_RDATA <= ram[RAM_ADDR];
        end
    end

    logic [DW-1:0] model [0:1023];

    typedef struct {
        int          due;
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int step_n = 0;

    function automatic logic [29:0] pa(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [95:0] pd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    // One clock step: drive inputs at the falling edge and retire any read due this cycle.
    task automatic cycle(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                         input logic [29:0] a, input logic [95:0] d);
        exp_t sb;
        @(negedge CLK);
        step_n++;
        REQ = r; WE = w; LOCK = l; ADDR = a; WDATA = d;
        if (q.size() > 0 && q[0].due == step_n) begin
            sb = q.pop_front();
            checks++;
            if (RVALID !== sb.id || RDATA !== sb.data) begin
                errors++;
                $display("FAIL read_return step %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                         step_n, RVALID, RDATA, sb.id, sb.data);
            end
        end else begin
            checks++;
            if (RVALID !== 3'b000) begin
                errors++;
                $display("FAIL idle_rvalid step %0d: got rvalid=%b, expected 000", step_n, RVALID);
            end
        end
        #1;
    endtask

    task automatic expect_read(input logic [2:0] id, input logic [9:0] addr);
        q.push_back('{due: step_n + 1, id: id, data: model[addr]});
    endtask

    task automatic test_reset();
        logic [31:0] v;
        RST_N = 1'b0; REQ = 3'b000; WE = 3'b000; LOCK = 3'b000; ADDR = '0; WDATA = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            v = (i == 5) ? 32'h1234_5678 : $urandom;
            load_en = 1'b1; load_addr = 10'(i); load_data = v; model[i] = v;
        end
        @(negedge CLK);
        load_en = 1'b0;
        #1;
        checks++;
        if (RVALID !== 3'b000 || GNT !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got rvalid=%b gnt=%b, expected 000/000", RVALID, GNT);
        end
        checks++;
        if (RAM_EN !== 1'b0 || RAM_WE !== 1'b0 || RAM_ADDR !== 10'd0 || RAM_WDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_ram: got en=%b we=%b addr=%h wdata=%h, expected all 0",
                     RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_single_read();
        cycle(3'b010, 3'b000, 3'b000, pa(10'd0, 10'd5, 10'd0), 96'd0);
        checks++;
        if (GNT !== 3'b010 || RAM_EN !== 1'b1 || RAM_ADDR !== 10'd5 || RAM_WE !== 1'b0) begin
            errors++;
            $display("FAIL single_read_grant: got gnt=%b en=%b addr=%h we=%b, expected 010 1 005 0",
                     GNT, RAM_EN, RAM_ADDR, RAM_WE);
        end
        expect_read(3'b010, 10'd5);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
        checks++;
        if (GNT !== 3'b000 || RAM_EN !== 1'b0) begin
            errors++;
            $display("FAIL idle_grant: got gnt=%b en=%b, expected 000 0", GNT, RAM_EN);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg;
        logic [9:0] ea;
        cycle(3'b100, 3'b000, 3'b000, pa(10'd0, 10'd0, 10'd7), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL rr_prime: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd7);
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, 3'b000, 3'b000, pa(10'd10, 10'd20, 10'd30), 96'd0);
            eg = 3'b001 << (k % 3);
            ea = (k % 3 == 0) ? 10'd10 : (k % 3 == 1) ? 10'd20 : 10'd30;
            checks++;
            if (GNT !== eg || RAM_ADDR !== ea) begin
                errors++;
                $display("FAIL rr_grant %0d: got gnt=%b addr=%h, expected %b %h", k, GNT, RAM_ADDR, eg, ea);
            end
            expect_read(eg, ea);
        end
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
    endtask

    task automatic test_lock_force_release();
        cycle(3'b100, 3'b000, 3'b100, pa(10'd40, 10'd41, 10'd50), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL lock_entry: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd50);
        for (int k = 1; k < ML; k++) begin
            cycle(3'b111, 3'b000, 3'b100, pa(10'd40, 10'd41, 10'(50 + k)), 96'd0);
            checks++;
            if (GNT !== 3'b100) begin
                errors++;
                $display("FAIL lock_burst %0d: got gnt=%b, expected 100", k, GNT);
            end
            expect_read(3'b100, 10'(50 + k));
        end
        cycle(3'b111, 3'b000, 3'b100, pa(10'd40, 10'd41, 10'd60), 96'd0);
        checks++;
        if (GNT !== 3'b001) begin
            errors++;
            $display("FAIL force_release: got gnt=%b, expected 001", GNT);
        end
        expect_read(3'b001, 10'd40);
        cycle(3'b110, 3'b000, 3'b100, pa(10'd0, 10'd41, 10'd60), 96'd0);
        checks++;
        if (GNT !== 3'b010) begin
            errors++;
            $display("FAIL owner_ranked_last: got gnt=%b, expected 010", GNT);
        end
        expect_read(3'b010, 10'd41);
        cycle(3'b100, 3'b000, 3'b000, pa(10'd0, 10'd0, 10'd60), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL after_release: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd60);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
    endtask

    task automatic test_lock_drop();
        cycle(3'b100, 3'b000, 3'b100, pa(10'd0, 10'd61, 10'd70), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL drop_entry: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd70);
        cycle(3'b110, 3'b000, 3'b100, pa(10'd0, 10'd61, 10'd71), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL drop_held: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd71);
        cycle(3'b010, 3'b000, 3'b100, pa(10'd0, 10'd61, 10'd0), 96'd0);
        checks++;
        if (GNT !== 3'b000 || RAM_EN !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_grant: got gnt=%b en=%b, expected 000 0", GNT, RAM_EN);
        end
        cycle(3'b010, 3'b000, 3'b000, pa(10'd0, 10'd61, 10'd0), 96'd0);
        checks++;
        if (GNT !== 3'b010) begin
            errors++;
            $display("FAIL drop_next: got gnt=%b, expected 010", GNT);
        end
        expect_read(3'b010, 10'd61);
        cycle(3'b001, 3'b000, 3'b000, pa(10'd63, 10'd0, 10'd0), 96'd0);
        checks++;
        if (GNT !== 3'b001) begin
            errors++;
            $display("FAIL drop_arb: got gnt=%b, expected 001", GNT);
        end
        expect_read(3'b001, 10'd63);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
    endtask

    task automatic test_write_then_read();
        cycle(3'b010, 3'b010, 3'b000, pa(10'd0, 10'h3FF, 10'd0),
              pd(32'd0, 32'hDEAD_BEEF, 32'd0));
        checks++;
        if (GNT !== 3'b010 || RAM_WE !== 1'b1 || RAM_ADDR !== 10'h3FF || RAM_WDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_drive: got gnt=%b we=%b addr=%h wdata=%h, expected 010 1 3ff deadbeef",
                     GNT, RAM_WE, RAM_ADDR, RAM_WDATA);
        end
        model[10'h3FF] = 32'hDEAD_BEEF;
        cycle(3'b001, 3'b000, 3'b000, pa(10'h3FF, 10'd0, 10'd0), 96'd0);
        checks++;
        if (GNT !== 3'b001 || RAM_WE !== 1'b0 || RVALID !== 3'b000) begin
            errors++;
            $display("FAIL read_after_write: got gnt=%b we=%b rvalid=%b, expected 001 0 000", GNT, RAM_WE, RVALID);
        end
        expect_read(3'b001, 10'h3FF);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            cycle(3'b001, 3'b000, 3'b000, pa(10'(100 + k), 10'd0, 10'd0), 96'd0);
            checks++;
            if (GNT !== 3'b001 || RAM_ADDR !== 10'(100 + k)) begin
                errors++;
                $display("FAIL back_to_back %0d: got gnt=%b addr=%h, expected 001 %h", k, GNT, RAM_ADDR, 10'(100 + k));
            end
            expect_read(3'b001, 10'(100 + k));
        end
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
    endtask

    task automatic test_async_reset();
        cycle(3'b100, 3'b000, 3'b100, pa(10'd0, 10'd0, 10'd200), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL ar_entry: got gnt=%b, expected 100", GNT);
        end
        expect_read(3'b100, 10'd200);
        cycle(3'b100, 3'b000, 3'b100, pa(10'd0, 10'd0, 10'd201), 96'd0);
        checks++;
        if (GNT !== 3'b100) begin
            errors++;
            $display("FAIL ar_burst: got gnt=%b, expected 100", GNT);
        end
        @(posedge CLK);
        #2;
        checks++;
        if (RVALID !== 3'b100) begin
            errors++;
            $display("FAIL ar_inflight: got rvalid=%b, expected 100", RVALID);
        end
        RST_N = 1'b0;
        REQ = 3'b000; LOCK = 3'b000;
        #1;
        q.delete();
        checks++;
        if (RVALID !== 3'b000 || GNT !== 3'b000) begin
            errors++;
            $display("FAIL ar_clear: got rvalid=%b gnt=%b, expected 000 000", RVALID, GNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(3'b111, 3'b000, 3'b000, pa(10'd210, 10'd211, 10'd212), 96'd0);
        checks++;
        if (GNT !== 3'b001) begin
            errors++;
            $display("FAIL ar_first_grant: got gnt=%b, expected 001", GNT);
        end
        expect_read(3'b001, 10'd210);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
        cycle(3'b000, 3'b000, 3'b000, '0, 96'd0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_force_release();
        test_lock_drop();
        test_write_then_read();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_ram_arbiter.md
# nn_ram_arbiter

Shares the single-port SoC RAM between three requesters on the nnRv SoC: M0 is instruction fetch, M1 is CPU load/store, and M2 is the display/VGA line reader. Each cycle the block grants at most one requester, using round-robin priority with an optional bounded lock for bursts. It drives the RAM port directly and returns read data with a fixed one-cycle latency. A requester that does not receive a grant sees it as a stall, and the CPU uses this in place of its tied-off `memory_stall`.

## Interface
Parameters:
- AW, 10, RAM word-address width (1024 words)
- DW, 32, data width
- MAX_LOCK, 16, maximum consecutive grants to one locked owner (range 1..255)

Ports:
- CLK  in  1  clock; all state updates on its rising edge
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low
- REQ  in  3  per-requester request; bit i is Mi
- WE  in  3  per-requester write enable (1 = write, 0 = read)
- LOCK  in  3  per-requester lock request; holds arbitration for bursts
- ADDR  in  3*AW  packed word addresses; Mi uses ADDR[i*AW +: AW]
- WDATA  in  3*DW  packed write data; Mi uses WDATA[i*DW +: DW]
- GNT  out  3  one-hot or zero; request accepted this cycle
- RVALID  out  3  read data on RDATA belongs to Mi this cycle
- RDATA  out  DW  read data, shared by all requesters
- RAM_EN  out  1  RAM access strobe
- RAM_WE  out  1  RAM write strobe
- RAM_ADDR  out  AW  RAM word address
- RAM_WDATA  out  DW  RAM write data
- RAM_RDATA  in  DW  RAM read data, valid the cycle after RAM_EN with RAM_WE=0

## Operation
- State machine:
  - ARB: all requesters compete.
  - LOCKED: only the owner recorded in `owner[1:0]` can be granted.
- Round-robin in ARB:
  - `last[1:0]` holds the most recently granted requester.
  - Search order is last+1, last+2, last (mod 3).
  - The first requester in that order with REQ=1 is granted.
- Lock entry: a grant in ARB with LOCK[i]=1 moves to LOCKED with owner=i and `lcnt`=1.
- In LOCKED, a cycle with REQ[owner]=1:
  - GNT[owner]=1 and `lcnt` increments.
  - If LOCK[owner]=0 on that grant, or `lcnt` reaches MAX_LOCK, return to ARB after this grant.
- In LOCKED, a cycle with REQ[owner]=0: no grant, return to ARB immediately. Other requesters compete from the next cycle.
- `last` updates on every grant. A force-released owner therefore has lowest priority next.
- MAX_LOCK=1: a lock never persists past its first grant.
- RAM drive (combinational from the granted requester):
  - RAM_EN = |GNT.
  - RAM_WE, RAM_ADDR and RAM_WDATA come from the granted requester.
  - With no grant, all RAM outputs are 0.
- Read return:
  - RVALID[i] is registered as GNT[i] & ~WE[i].
  - RDATA = RAM_RDATA passed through.
  - A write grant produces no RVALID.
- Requester rule: REQ, WE, LOCK, ADDR and WDATA are held stable from assertion until the cycle GNT[i]=1. They may change the cycle after the grant.
- Address width: ADDR is a word address. The byte-to-word conversion (addr[31:2]) and decoding of peripheral addresses at 0x8000_xxxx are done by the requester, not here.

## Timing
- GNT is combinational from REQ/LOCK and the registered state, with zero-cycle accept.
- One access per cycle; back-to-back grants are allowed, including to the same requester.
- Read latency: grant in cycle N gives RVALID and RDATA in cycle N+1.
- Write then read of the same address in consecutive cycles returns the new data (RAM is write-before-read across cycles).
- Reset values:
  - state=ARB, last=2 (M0 first after reset), owner=0, lcnt=0.
  - RVALID=0.
  - GNT, RAM_EN and RAM_WE follow the combinational rule, so they are 0 when REQ=0.
- Reset asserted mid-operation, including mid-lock or with a read in flight: everything clears asynchronously and the pending RVALID is dropped. RVALID is 0 in the first cycle after release.
- All three requesting every cycle with no locks: grants rotate M0, M1, M2, M0, ... Worst-case wait is 2 cycles unlocked and MAX_LOCK+1 cycles with a lock.

## Test plan
- Reset and single read: release reset, preload RAM[5]=0x12345678, assert M1 read at ADDR=5. Expect GNT=3'b010 in the same cycle, RAM_EN=1, RAM_ADDR=5. Next cycle RVALID=3'b010 and RDATA=0x12345678.
- Round-robin: hold REQ=3'b111 with all reads for 6 cycles. Expect GNT sequence 001, 010, 100, 001, 010, 100, with matching RVALID one cycle later.
- Lock with force release: MAX_LOCK=4, M2 issues a locked read burst while M0 and M1 request continuously. Expect 4 consecutive M2 grants, then M0 granted and M2 ranked last.
- Lock drop: M2 locked, deasserts REQ for one cycle while M1 requests. Expect no grant that cycle, M1 granted the next cycle, state back to ARB.
- Write then read: M1 writes 0xDEADBEEF to ADDR=0x3FF, then M0 reads 0x3FF in the next cycle. Expect the write produces no RVALID, then RVALID[0]=1 with RDATA=0xDEADBEEF.
- Async reset mid-burst: pull RST_N low between clock edges during an M2 lock with a read in flight. Expect RVALID=0 immediately, and after release the first grant with REQ=3'b111 goes to M0.
